dp_mem_responder: RTL
=====================

Name: dp_mem_responder

Overview:
- Responder end of the datapath-to-memory request interface: accepts the datapath's instruction fetch and data load/store requests and serves them from a single-ported RAM.
- Returns ihit/dhit with imemload/dmemload.
- Arbitrates the two request streams: data has priority, one access at a time.
- Sits between the datapath and the RAM port, in place of the cache for cacheless builds.

Parameters:
- MAX_WAIT, default 255: cycles an access may wait for RAM before it is aborted as an error.
- ERR_WORD, default 32'hBAD1BAD1: load data returned when an access errors or times out.

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- halt  input  1  datapath halted; no new instruction fetches accepted.
- imemREN  input  1  instruction fetch request.
- imemaddr  input  32  fetch byte address.
- ihit  output  1  fetch complete, one-cycle pulse.
- imemload  output  32  fetched instruction.
- dmemREN  input  1  data load request.
- dmemWEN  input  1  data store request.
- dmemaddr  input  32  data byte address.
- dmemstore  input  32  store data.
- dhit  output  1  data access complete, one-cycle pulse.
- dmemload  output  32  loaded data.
- ramREN  output  1  RAM read enable.
- ramWEN  output  1  RAM write enable.
- ramaddr  output  32  RAM word-aligned byte address.
- ramstore  output  32  RAM write data.
- ramload  input  32  RAM read data.
- ramstate  input  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
- mem_err  output  1  sticky error flag.

Behaviour:
- Reset (async, nRST low): state IDLE; all outputs 0; wait counter 0. Reset mid-access abandons the access immediately: ramREN/ramWEN drop without waiting for the clock, and no hit is issued.
- FSM states: IDLE, DACC, IACC, DRESP, IRESP.
- IDLE
  - If dmemREN or dmemWEN: latch dmemaddr, dmemstore and a write flag (dmemWEN), then go to DACC.
  - Else if imemREN and not halt: latch imemaddr, then go to IACC.
  - Else stay in IDLE.
  - Data wins a simultaneous request. The fetch is served on the next IDLE visit.
- dmemREN and dmemWEN both high: treated as a store; the write flag wins.
- DACC / IACC
  - ramaddr = {latched_addr[31:2], 2'b00}.
  - DACC: ramWEN = write flag; ramREN = not write flag; ramstore = latched store data.
  - IACC: ramREN = 1, ramWEN = 0.
  - Outputs are registered/decoded from state only; datapath input changes during an access are ignored.
  - ramstate ACCESS: capture ramload into dmemload (DACC read) or imemload (IACC), then go to DRESP / IRESP. A store leaves dmemload unchanged.
  - ramstate ERROR, or wait counter reaches MAX_WAIT: set mem_err, load ERR_WORD into the relevant load register (stores leave dmemload unchanged), then go to the response state.
  - FREE/BUSY: increment the wait counter and stay.
  - The wait counter clears on entry to any ACC state.
- DRESP: dhit = 1 for exactly this cycle; ram enables 0; go to IDLE.
- IRESP: ihit = 1 for exactly this cycle; ram enables 0; go to IDLE.
- Latency: minimum 3 cycles from a request sampled in IDLE to the hit pulse (IDLE→ACC→RESP, ACCESS in the first ACC cycle).
- The requester holds its request stable until the hit and may change its address/enables in the hit cycle. IDLE re-samples the next cycle, so a stale request is never served twice.
- ihit and dhit are never high in the same cycle.
- imemload/dmemload hold their last value until the next capture.
- halt asserting during IACC does not abort; the fetch completes. After that no fetch is accepted while halt is high; data requests are still served.
- mem_err stays 1 until reset.

Test Plan:
- Read fetch: reset, imemREN=1, imemaddr=0x00000044, ramstate ACCESS on the first IACC cycle with ramload=0x8C220004. Required: ramaddr=0x44 with ramREN=1; ihit pulses exactly once, 3 cycles after the request; imemload=0x8C220004; dhit=0.
- Data priority on a simultaneous request: imemREN=1 and dmemREN=1 with dmemaddr=0x00000103, ramload=0x12345678. Required: the data access is served first (ramaddr=0x100, dhit pulse, dmemload=0x12345678). The fetch follows, with ihit 3 cycles after dhit.
- Store with busy RAM: dmemWEN=1, dmemaddr=0x200, dmemstore=0xDEADBEEF, ramstate BUSY for 5 cycles then ACCESS. Required: ramWEN=1, ramstore=0xDEADBEEF held throughout; dhit 1 cycle after ACCESS; dmemload unchanged.
- Timeout: MAX_WAIT=4, dmemREN=1, ramstate held FREE. Required: after 4 wait cycles, dmemload=0xBAD1BAD1, mem_err=1, single dhit; mem_err still 1 after 10 further idle cycles.
- Halt gating: halt=1, imemREN=1. Required: no ramREN, no ihit for 20 cycles. A dmemREN=1 issued meanwhile still completes with dhit.
- Reset mid-access: nRST low while in DACC with ramREN=1. Required: ramREN, ramWEN, dhit and mem_err all 0 immediately (asynchronously). After nRST is released, the FSM is in IDLE and serves a new fetch normally.

Source files
------------

// File: rtl/dp_mem_responder.sv
// Purpose : serves datapath instruction fetches and data loads/stores from one single-ported RAM (cacheless build).
// Latency : 3 cycles minimum from a request seen in IDLE to its ihit/dhit pulse (IDLE -> ACC -> RESP).
// Backpr. : one access in flight; requester holds its request until the hit; RAM FREE/BUSY stalls up to MAX_WAIT.
//
// Ports:
//   CLK, nRST                     clock (rising edge), asynchronous active-low reset
//   halt                          blocks new instruction fetches (data still served)
//   imemREN/imemaddr -> ihit/imemload                     fetch request / completion
//   dmemREN/dmemWEN/dmemaddr/dmemstore -> dhit/dmemload   data request / completion
//   ramREN/ramWEN/ramaddr/ramstore, ramload/ramstate      RAM port
//   mem_err                       sticky: set on RAM ERROR or wait timeout, cleared by reset only
module dp_mem_responder #(
   parameter int unsigned MAX_WAIT = 255,
   parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        halt,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   input  logic        dmemREN,
   input  logic        dmemWEN,
   input  logic [31:0] dmemaddr,
   input  logic [31:0] dmemstore,
   output logic        dhit,
   output logic [31:0] dmemload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   output logic        mem_err
);

   localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] DACC  = 3'd1;
   localparam logic [2:0] IACC  = 3'd2;
   localparam logic [2:0] DRESP = 3'd3;
   localparam logic [2:0] IRESP = 3'd4;

   localparam logic [1:0] RS_ACCESS = 2'd2;
   localparam logic [1:0] RS_ERROR  = 2'd3;

   logic [2:0]    state_q, state_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   store_q, store_d;
   logic          wr_q, wr_d;
   logic [WW-1:0] wait_q, wait_d;
   logic [31:0]   iload_q, iload_d;
   logic [31:0]   dload_q, dload_d;
   logic          err_q, err_d;

   logic in_acc;
   logic acc_fail;

   assign in_acc   = (state_q == DACC) || (state_q == IACC);
   // ACCESS takes precedence over a timeout landing in the same cycle.
   assign acc_fail = (ramstate == RS_ERROR) || (wait_q == WW'(MAX_WAIT));

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      store_d = store_q;
      wr_d    = wr_q;
      wait_d  = wait_q;
      iload_d = iload_q;
      dload_d = dload_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            // Data wins; a concurrent fetch is picked up on the next IDLE visit.
            if (dmemREN || dmemWEN) begin
               state_d = DACC;
               addr_d  = dmemaddr;
               store_d = dmemstore;
               wr_d    = dmemWEN;
               wait_d  = '0;
            end else if (imemREN && !halt) begin
               state_d = IACC;
               addr_d  = imemaddr;
               wr_d    = 1'b0;
               wait_d  = '0;
            end
         end
         DACC, IACC: begin
            if (ramstate == RS_ACCESS || acc_fail) begin
               if (ramstate != RS_ACCESS) begin
                  err_d = 1'b1;
               end
               if (state_q == IACC) begin
                  iload_d = (ramstate == RS_ACCESS) ? ramload : ERR_WORD;
                  state_d = IRESP;
               end else begin
                  // Stores never disturb dmemload.
                  if (!wr_q) begin
                     dload_d = (ramstate == RS_ACCESS) ? ramload : ERR_WORD;
                  end
                  state_d = DRESP;
               end
            end else begin
               wait_d = wait_q + WW'(1);
            end
         end
         DRESP, IRESP: state_d = IDLE;
         default:      state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         addr_q  <= '0;
         store_q <= '0;
         wr_q    <= 1'b0;
         wait_q  <= '0;
         iload_q <= '0;
         dload_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         store_q <= store_d;
         wr_q    <= wr_d;
         wait_q  <= wait_d;
         iload_q <= iload_d;
         dload_q <= dload_d;
         err_q   <= err_d;
      end
   end

   // Everything below decodes from registered state, so an async reset
   // drops the RAM enables and hits without waiting for a clock edge.
   assign ramREN   = in_acc && !(state_q == DACC && wr_q);
   assign ramWEN   = (state_q == DACC) && wr_q;
   assign ramaddr  = {addr_q[31:2], 2'b00};
   assign ramstore = store_q;
   assign ihit     = (state_q == IRESP);
   assign dhit     = (state_q == DRESP);
   assign imemload = iload_q;
   assign dmemload = dload_q;
   assign mem_err  = err_q;

endmodule
